// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the traffic-intersection controller.
// Lamp triples are {red, yellow, green}.
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALL_RED = 2'd0,
        PH_GREEN   = 2'd1,
        PH_YELLOW  = 2'd2,
        PH_WALK    = 2'd3
    } phase_t;

    localparam logic [2:0] LAMP_RED  = 3'b100;
    localparam logic [2:0] LAMP_YEL  = 3'b010;
    localparam logic [2:0] LAMP_GRN  = 3'b001;
    localparam logic [2:0] LAMP_TEST = 3'b111;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_rr_arbiter.sv
// Combinational round-robin search: first set req bit after start, wrapping.
// With no request set, grant_idx echoes start and any_req is low.
module traffic_rr_arbiter #(
    parameter int N_APPROACH = 4
) (
    input  logic [N_APPROACH-1:0]         req,
    input  logic [$clog2(N_APPROACH)-1:0] start,
    output logic [$clog2(N_APPROACH)-1:0] grant_idx,
    output logic                          any_req
);
    localparam int IW = $clog2(N_APPROACH);

    logic [IW-1:0] j;

    // Scan farthest-first so the nearest requester after start wins.
    always_comb begin
        grant_idx = start;
        any_req   = 1'b0;
        j         = '0;
        for (int k = N_APPROACH; k >= 1; k--) begin
            j = IW'((int'(start) + k) % N_APPROACH);
            if (req[j]) begin
                grant_idx = j;
                any_req   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// N-approach round-robin traffic controller: GREEN -> YELLOW -> ALL_RED.
// Define TRAFFIC_PED_EN to add the pedestrian WALK phase (ped_req / ped_walk).
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_APPROACH    = 4,
    parameter int MIN_GREEN     = 8,
    parameter int YELLOW_CYCLES = 3,
    parameter int ALLRED_CYCLES = 2,
    parameter int WALK_CYCLES   = 6
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic [N_APPROACH-1:0]         car_sensor,
`ifdef TRAFFIC_PED_EN
    input  logic                          ped_req,
    output logic                          ped_walk,
`endif
    output logic [3*N_APPROACH-1:0]       lights,
    output logic [$clog2(N_APPROACH)-1:0] active_idx,
    output logic [1:0]                    phase
);
    localparam int IW   = $clog2(N_APPROACH);
    localparam int MAXD = max_of(max_of(MIN_GREEN, YELLOW_CYCLES),
                                 max_of(ALLRED_CYCLES, WALK_CYCLES));
    localparam int CW   = $clog2(MAXD) + 1;

    phase_t                  state;
    logic [CW-1:0]           cnt;
    logic [N_APPROACH-1:0]   req, req_set, active_oh, next_oh;
    logic [IW-1:0]           grant_idx, next_idx;
    logic                    any_req, foreign, walk_pending;
    logic                    ar_done, gr_done, ye_done, wk_done, leave;
    logic [3*N_APPROACH-1:0] lights_nxt;

`ifdef TRAFFIC_PED_EN
    localparam bit PED_EN = 1'b1;
    logic preq;
    assign walk_pending = preq;
    assign wk_done      = (state == PH_WALK) && (cnt == CW'(WALK_CYCLES - 1));
`else
    localparam bit PED_EN = 1'b0;
    assign walk_pending = 1'b0;
    assign wk_done      = 1'b0;
`endif

    traffic_rr_arbiter #(.N_APPROACH(N_APPROACH)) u_arb (
        .req       (req),
        .start     (active_idx),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    assign next_idx = any_req ? grant_idx : active_idx;
    assign foreign  = (|(req & ~active_oh)) | walk_pending;
    assign ar_done  = (state == PH_ALL_RED) && (cnt == CW'(ALLRED_CYCLES - 1));
    assign gr_done  = (state == PH_GREEN) && (cnt >= CW'(MIN_GREEN - 1)) && foreign;
    assign ye_done  = (state == PH_YELLOW) && (cnt == CW'(YELLOW_CYCLES - 1));
    assign leave    = ar_done | gr_done | ye_done | wk_done;
    assign phase    = state;

    always_comb begin
        active_oh  = '0;
        next_oh    = '0;
        lights_nxt = '0;
        for (int i = 0; i < N_APPROACH; i++) begin
            active_oh[i] = (active_idx == IW'(i));
            next_oh[i]   = (next_idx == IW'(i));
            lights_nxt[3*i +: 3] = LAMP_RED;
            if (active_oh[i] && state == PH_GREEN)  lights_nxt[3*i +: 3] = LAMP_GRN;
            if (active_oh[i] && state == PH_YELLOW) lights_nxt[3*i +: 3] = LAMP_YEL;
        end
        // The approach holding green cannot re-request itself.
        req_set = car_sensor;
        if (state == PH_GREEN) req_set = car_sensor & ~active_oh;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= PH_ALL_RED;
            cnt        <= '0;
            active_idx <= IW'(N_APPROACH - 1);
            req        <= '0;
            lights     <= {N_APPROACH{LAMP_TEST}};
        end else begin
            lights <= lights_nxt;
            cnt    <= leave ? '0 : ((&cnt) ? cnt : cnt + CW'(1));
            req    <= req | req_set;
            case (state)
                PH_ALL_RED: if (ar_done) begin
                    if (walk_pending) begin
                        state <= PH_WALK;
                    end else begin
                        state      <= PH_GREEN;
                        active_idx <= next_idx;
                        // Clear beats a same-cycle set for the approach entering green.
                        req        <= (req | req_set) & ~next_oh;
                    end
                end
                PH_GREEN:  if (gr_done) state <= PH_YELLOW;
                PH_YELLOW: if (ye_done) state <= PH_ALL_RED;
                default:   if (wk_done || !PED_EN) state <= PH_ALL_RED;
            endcase
        end
    end

`ifdef TRAFFIC_PED_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            preq     <= 1'b0;
            ped_walk <= 1'b0;
        end else begin
            preq     <= (ar_done && preq) ? 1'b0 : (preq | ped_req);
            ped_walk <= (state == PH_WALK);
        end
    end
`endif

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Self-checking bench for traffic_phase_ctrl: vector table plus hand sequences.
// Define TRAFFIC_PED_EN to also exercise the WALK phase.
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [3:0]  car_sensor = '0;
    logic [11:0] lights;
    logic [1:0]  active_idx;
    logic [1:0]  phase;
`ifdef TRAFFIC_PED_EN
    logic        ped_req = 1'b0;
    logic        ped_walk;
`endif

    traffic_phase_ctrl #(
        .N_APPROACH(4), .MIN_GREEN(8), .YELLOW_CYCLES(3),
        .ALLRED_CYCLES(2), .WALK_CYCLES(6)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .car_sensor (car_sensor),
`ifdef TRAFFIC_PED_EN
        .ped_req    (ped_req),
        .ped_walk   (ped_walk),
`endif
        .lights     (lights),
        .active_idx (active_idx),
        .phase      (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sens;
        logic        ped;
        int          n_cyc;
        logic [1:0]  ph;
        logic [1:0]  idx;
        logic [11:0] lt;
        logic        walk;
    } vec_t;

    typedef struct {
        logic [1:0]  ph;
        logic [1:0]  idx;
        logic [11:0] lt;
        logic        walk;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   rrq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [3:0] s, input logic p, input int n,
                                input logic [1:0] ph, input logic [1:0] idx,
                                input logic [11:0] lt, input logic w);
        vec_t v;
        v.sens = s; v.ped = p; v.n_cyc = n; v.ph = ph; v.idx = idx; v.lt = lt; v.walk = w;
        tbl.push_back(v);
    endfunction

    // Each row: inputs held for one edge, then idle until n_cyc edges have passed.
    task automatic run_tbl(input string tag);
        exp_t e;
        while (tbl.size() > 0) begin
            vec_t v;
            v = tbl.pop_front();
            car_sensor = v.sens;
`ifdef TRAFFIC_PED_EN
            ped_req = v.ped;
`endif
            e.ph = v.ph; e.idx = v.idx; e.lt = v.lt; e.walk = v.walk;
            sbq.push_back(e);
            tick();
            car_sensor = '0;
`ifdef TRAFFIC_PED_EN
            ped_req = 1'b0;
`endif
            repeat (v.n_cyc - 1) tick();
            e = sbq.pop_front();
            chk({tag, "_phase"}, 16'(phase), 16'(e.ph));
            chk({tag, "_idx"}, 16'(active_idx), 16'(e.idx));
            chk({tag, "_lights"}, 16'(lights), 16'(e.lt));
`ifdef TRAFFIC_PED_EN
            chk({tag, "_walk"}, 16'(ped_walk), 16'(e.walk));
`endif
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prevph;
        int dur, ngreen;
        bit counting;

        #1 n_rst = 1'b0;
        #2;
        chk("rst_lights", 16'(lights), 16'hFFF);
        chk("rst_phase", 16'(phase), 16'(PH_ALL_RED));
        chk("rst_idx", 16'(active_idx), 16'd3);
`ifdef TRAFFIC_PED_EN
        chk("rst_walk", 16'(ped_walk), 16'd0);
`endif
        #5 n_rst = 1'b1;

        // Power-up: all red, then rest-on-green for approach 3.
        add(4'b0000, 0, 1,   PH_ALL_RED, 2'd3, 12'h924, 0);
        add(4'b0000, 0, 1,   PH_GREEN,   2'd3, 12'h924, 0);
        add(4'b0000, 0, 1,   PH_GREEN,   2'd3, 12'h324, 0);
        add(4'b0000, 0, 100, PH_GREEN,   2'd3, 12'h324, 0);
        // Pulse approach 1 while 3 rests: yellow x3, all-red x2, green on 1.
        add(4'b0010, 0, 1,   PH_GREEN,   2'd3, 12'h324, 0);
        add(4'b0000, 0, 1,   PH_YELLOW,  2'd3, 12'h324, 0);
        add(4'b0000, 0, 1,   PH_YELLOW,  2'd3, 12'h524, 0);
        add(4'b0000, 0, 2,   PH_ALL_RED, 2'd3, 12'h524, 0);
        add(4'b0000, 0, 1,   PH_ALL_RED, 2'd3, 12'h924, 0);
        add(4'b0000, 0, 1,   PH_GREEN,   2'd1, 12'h924, 0);
        add(4'b0000, 0, 1,   PH_GREEN,   2'd1, 12'h90C, 0);
        // Early request at green count 2: must hold green through count 7.
        add(4'b1000, 0, 1,   PH_GREEN,   2'd1, 12'h90C, 0);
        add(4'b0000, 0, 5,   PH_GREEN,   2'd1, 12'h90C, 0);
        add(4'b0000, 0, 1,   PH_YELLOW,  2'd1, 12'h90C, 0);
        add(4'b0000, 0, 1,   PH_YELLOW,  2'd1, 12'h914, 0);
        add(4'b0000, 0, 4,   PH_GREEN,   2'd3, 12'h924, 0);
        add(4'b0000, 0, 1,   PH_GREEN,   2'd3, 12'h324, 0);
        // Served requests are gone: 3 keeps resting.
        add(4'b0000, 0, 20,  PH_GREEN,   2'd3, 12'h324, 0);
        run_tbl("seq");

        // Sensors 0..2 held: rotation 0,1,2,0 with 8-cycle greens.
        rrq = '{0, 1, 2, 0};
        car_sensor = 4'b0111;
        prevph = phase;
        dur = 0; ngreen = 0; counting = 0;
        for (int c = 0; c < 300 && ngreen < 4; c++) begin
            tick();
            if (phase == PH_GREEN && prevph != PH_GREEN) begin
                chk("rr_idx", 16'(active_idx), 16'(rrq.pop_front()));
                ngreen++; dur = 1; counting = 1;
            end else if (phase == PH_GREEN && counting) begin
                dur++;
            end else if (phase != PH_GREEN && prevph == PH_GREEN && counting) begin
                chk("green_len", 16'(dur), 16'd8);
                counting = 0;
            end
            prevph = phase;
        end
        chk("rr_greens_seen", 16'(ngreen), 16'd4);

        // Reset during yellow with requests pending.
        for (int c = 0; c < 60 && phase != PH_YELLOW; c++) tick();
        chk("wait_yellow", 16'(phase), 16'(PH_YELLOW));
        car_sensor = '0;
        #3 n_rst = 1'b0;
        #1;
        chk("arst_lights", 16'(lights), 16'hFFF);
        chk("arst_phase", 16'(phase), 16'(PH_ALL_RED));
        chk("arst_idx", 16'(active_idx), 16'd3);
        #2 n_rst = 1'b1;
        add(4'b0000, 0, 1,  PH_ALL_RED, 2'd3, 12'h924, 0);
        add(4'b0000, 0, 1,  PH_GREEN,   2'd3, 12'h924, 0);
        add(4'b0000, 0, 1,  PH_GREEN,   2'd3, 12'h324, 0);
        add(4'b0000, 0, 50, PH_GREEN,   2'd3, 12'h324, 0);
        run_tbl("rst");

`ifdef TRAFFIC_PED_EN
        // Pedestrian and approach 2 together: WALK first, then 2.
        add(4'b0100, 1, 1, PH_GREEN,   2'd3, 12'h324, 0);
        add(4'b0000, 0, 1, PH_YELLOW,  2'd3, 12'h324, 0);
        add(4'b0000, 0, 5, PH_WALK,    2'd3, 12'h924, 0);
        add(4'b0000, 0, 1, PH_WALK,    2'd3, 12'h924, 1);
        add(4'b0000, 0, 5, PH_ALL_RED, 2'd3, 12'h924, 1);
        add(4'b0000, 0, 1, PH_ALL_RED, 2'd3, 12'h924, 0);
        add(4'b0000, 0, 1, PH_GREEN,   2'd2, 12'h924, 0);
        add(4'b0000, 0, 1, PH_GREEN,   2'd2, 12'h864, 0);
        run_tbl("ped");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
